// File: rtl/cache_refill_ctrl_pkg.sv
// cache_refill_ctrl_pkg: cache geometry and refill FSM state encoding shared
// by the refill controller and its helpers.
`default_nettype none

package cache_refill_ctrl_pkg;

  localparam int NUM_SETS = 256;
  localparam int NUM_WAYS = 4;
  localparam int INDEX_W  = 8;
  localparam int ADDR_W   = 16;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_VICTIM   = 3'd1;
  localparam logic [2:0] ST_WAIT_WAY = 3'd2;
  localparam logic [2:0] ST_REQ      = 3'd3;
  localparam logic [2:0] ST_FILL     = 3'd4;
  localparam logic [2:0] ST_DONE     = 3'd5;

  function automatic int tag_width(input int ofs_w);
    return ADDR_W - INDEX_W - ofs_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cache_refill_ctrl_way_onehot_normalize.sv
// way_onehot_normalize: reduces a victim-way vector to a single one-hot way,
// keeping the lowest set bit and falling back to way 0 when nothing is set.
`default_nettype none

module way_onehot_normalize
  import cache_refill_ctrl_pkg::*;
(
  input  logic [NUM_WAYS-1:0] way_i,
  output logic [NUM_WAYS-1:0] way_o
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    way_o    = '0;
    way_o[0] = 1'b1;
    for (int i = NUM_WAYS - 1; i >= 0; i--) begin
      if (way_i[i]) begin
        way_o    = '0;
        way_o[i] = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cache_refill_ctrl.sv
// cache_refill_ctrl: on a miss, obtains a victim way, reads the line from
// memory, writes each beat into the data array, then installs the tag.
`default_nettype none

module cache_refill_ctrl
  import cache_refill_ctrl_pkg::*;
#(
  parameter  int DATA_W = 32,
  parameter  int BEATS  = 4,
  localparam int OFS_W  = $clog2(BEATS),
  localparam int TAG_W  = ADDR_W - INDEX_W - OFS_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                miss_req,
  input  logic [ADDR_W-1:0]   miss_addr,
  output logic                busy,
  output logic                miss_ack,
  output logic                repl_enable,
  output logic [INDEX_W-1:0]  repl_set_addr,
  input  logic [NUM_WAYS-1:0] repl_way_sel,
  output logic                mem_rd_valid,
  input  logic                mem_rd_ready,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic                mem_data_valid,
  input  logic [DATA_W-1:0]   mem_data,
  output logic                wr_en,
  output logic [NUM_WAYS-1:0] wr_way,
  output logic [INDEX_W-1:0]  wr_set,
  output logic [OFS_W-1:0]    wr_word,
  output logic [DATA_W-1:0]   wr_data,
  output logic                tag_wr_en,
  output logic [TAG_W-1:0]    tag_wr
);

  logic [2:0]              state_q, state_d;
  logic [ADDR_W-1:OFS_W]   line_q, line_d;
  logic [NUM_WAYS-1:0]     way_q, way_d;
  logic [OFS_W-1:0]        cnt_q, cnt_d;
  logic [NUM_WAYS-1:0]     w_way_norm;
  logic [INDEX_W-1:0]      w_index;
  logic [TAG_W-1:0]        w_tag;
  logic                    w_last_beat;
  logic                    unused_ofs;

  // Only the line is kept; the word offset of the miss does not matter.
  assign unused_ofs  = ^miss_addr[OFS_W-1:0];
  assign w_index     = line_q[OFS_W +: INDEX_W];
  assign w_tag       = line_q[ADDR_W-1 -: TAG_W];
  assign w_last_beat = (cnt_q == OFS_W'(BEATS - 1));

  way_onehot_normalize u_way_norm (
    .way_i (repl_way_sel),
    .way_o (w_way_norm)
  );

  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    way_d   = way_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          line_d  = miss_addr[ADDR_W-1:OFS_W];
          state_d = ST_VICTIM;
        end
      end
      ST_VICTIM: state_d = ST_WAIT_WAY;
      ST_WAIT_WAY: begin
        way_d   = w_way_norm;
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_rd_ready) begin
          cnt_d   = '0;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        if (mem_data_valid) begin
          cnt_d = cnt_q + 1'b1;
          if (w_last_beat) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = (state_q != ST_IDLE);
    repl_enable   = 1'b0;
    repl_set_addr = '0;
    mem_rd_valid  = 1'b0;
    mem_rd_addr   = '0;
    wr_en         = 1'b0;
    wr_way        = '0;
    wr_set        = '0;
    wr_word       = '0;
    wr_data       = '0;
    tag_wr_en     = 1'b0;
    tag_wr        = '0;
    miss_ack      = 1'b0;
    case (state_q)
      ST_VICTIM: begin
        repl_enable   = 1'b1;
        repl_set_addr = w_index;
      end
      ST_REQ: begin
        mem_rd_valid = 1'b1;
        mem_rd_addr  = {line_q, {OFS_W{1'b0}}};
      end
      ST_FILL: begin
        if (mem_data_valid) begin
          wr_en   = 1'b1;
          wr_way  = way_q;
          wr_set  = w_index;
          wr_word = cnt_q;
          wr_data = mem_data;
        end
      end
      ST_DONE: begin
        tag_wr_en = 1'b1;
        tag_wr    = w_tag;
        miss_ack  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      line_q  <= '0;
      way_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      way_q   <= way_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
// tb_cache_refill_ctrl: directed and randomized refills checked against a
// transaction-level expectation of the refill sequence.
`default_nettype none

module tb_cache_refill_ctrl;

  localparam int DATA_W = 32;
  localparam int BEATS  = 4;
  localparam int OFS_W  = $clog2(BEATS);
  localparam int TAG_W  = 16 - 8 - OFS_W;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              miss_req = 1'b0;
  logic [15:0]       miss_addr = '0;
  logic              busy, miss_ack, repl_enable, mem_rd_valid, wr_en, tag_wr_en;
  logic [7:0]        repl_set_addr, wr_set;
  logic [3:0]        repl_way_sel = '0;
  logic              mem_rd_ready = 1'b0;
  logic [15:0]       mem_rd_addr;
  logic              mem_data_valid = 1'b0;
  logic [DATA_W-1:0] mem_data = '0;
  logic [3:0]        wr_way;
  logic [OFS_W-1:0]  wr_word;
  logic [DATA_W-1:0] wr_data;
  logic [TAG_W-1:0]  tag_wr;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;

  cache_refill_ctrl #(.DATA_W(DATA_W), .BEATS(BEATS)) dut (
    .clk            (clk),
    .rst            (rst),
    .miss_req       (miss_req),
    .miss_addr      (miss_addr),
    .busy           (busy),
    .miss_ack       (miss_ack),
    .repl_enable    (repl_enable),
    .repl_set_addr  (repl_set_addr),
    .repl_way_sel   (repl_way_sel),
    .mem_rd_valid   (mem_rd_valid),
    .mem_rd_ready   (mem_rd_ready),
    .mem_rd_addr    (mem_rd_addr),
    .mem_data_valid (mem_data_valid),
    .mem_data       (mem_data),
    .wr_en          (wr_en),
    .wr_way         (wr_way),
    .wr_set         (wr_set),
    .wr_word        (wr_word),
    .wr_data        (wr_data),
    .tag_wr_en      (tag_wr_en),
    .tag_wr         (tag_wr)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [127:0] all_outs();
    return {busy, miss_ack, repl_enable, repl_set_addr, mem_rd_valid, mem_rd_addr,
            wr_en, wr_way, wr_set, wr_word, wr_data, tag_wr_en, tag_wr};
  endfunction

  // Victim choice: lowest requested way, or way 0 if none requested.
  function automatic logic [3:0] exp_way(input logic [3:0] s);
    for (int i = 0; i < 4; i++) begin
      if (s[i]) return 4'(1 << i);
    end
    return 4'b0001;
  endfunction

  // One refill from the IDLE negedge back to the next IDLE negedge.
  // gap < 0 selects random idle cycles before each beat; rst_after > 0
  // aborts the refill with a reset after that many beats.
  task automatic do_miss(input logic [15:0] addr, input logic [3:0] wsel,
                         input int rdly, input int gap, input bit stray,
                         input int rst_after, input bit chain,
                         input logic [15:0] addr2);
    logic [7:0]        e_idx;
    logic [TAG_W-1:0]  e_tag;
    logic [15:0]       e_line;
    logic [3:0]        e_way;
    logic [DATA_W-1:0] d;
    int                extra;
    int                t_acc;
    int                g;
    e_idx  = 8'((addr >> OFS_W) & 16'h00FF);
    e_tag  = TAG_W'(addr >> (OFS_W + 8));
    e_line = addr & ~16'(BEATS - 1);
    e_way  = exp_way(wsel);
    extra  = rdly;

    chk("idle_busy", busy, 0);
    miss_req  = 1'b1;
    miss_addr = addr;
    step();
    t_acc = cyc;
    chk("victim_busy", busy, 1);
    chk("victim_repl_en", repl_enable, 1);
    chk("victim_set", repl_set_addr, e_idx);
    chk("victim_rd_valid", mem_rd_valid, 0);
    if (chain) miss_addr = addr2;
    repl_way_sel = wsel;
    step();
    chk("wait_repl_en", {repl_enable, repl_set_addr, mem_rd_valid}, 0);
    step();
    repl_way_sel = 4'($urandom);

    for (int i = 0; i <= rdly; i++) begin
      chk("req_valid", mem_rd_valid, 1);
      chk("req_addr", mem_rd_addr, e_line);
      mem_rd_ready   = (i == rdly);
      mem_data_valid = (i == rdly) ? stray : 1'($urandom);
      mem_data       = $urandom;
      #1;
      chk("req_no_wr", wr_en, 0);
      step();
    end
    mem_rd_ready   = 1'b0;
    mem_data_valid = 1'b0;

    for (int b = 0; b < BEATS; b++) begin
      g = (gap < 0) ? int'($urandom_range(0, 2)) : ((b == 0) ? 0 : gap);
      extra += g;
      for (int j = 0; j < g; j++) begin
        mem_data_valid = 1'b0;
        #1;
        chk("gap_no_wr", {wr_en, busy}, 2'b01);
        step();
      end
      d              = $urandom;
      mem_data       = d;
      mem_data_valid = 1'b1;
      #1;
      chk("beat_wr_en", wr_en, 1);
      chk("beat_way", wr_way, e_way);
      chk("beat_set", wr_set, e_idx);
      chk("beat_word", wr_word, b);
      chk("beat_data", wr_data, d);
      step();
      mem_data_valid = 1'b0;
      if (rst_after == b + 1) begin
        rst            = 1'b1;
        miss_req       = 1'b0;
        mem_data_valid = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_outs_zero", all_outs(), 0);
        for (int k = 0; k < 3; k++) begin
          mem_data_valid = 1'b1;
          mem_data       = $urandom;
          #1;
          chk("after_rst_quiet", {wr_en, miss_ack, tag_wr_en, busy}, 0);
          step();
        end
        mem_data_valid = 1'b0;
        return;
      end
    end

    #1;
    chk("done_ack", {miss_ack, tag_wr_en, wr_en}, 3'b110);
    chk("done_tag", tag_wr, e_tag);
    chk("ack_latency", cyc + 1 - t_acc, 4 + BEATS + extra);
    if (!chain) miss_req = 1'b0;
    step();
    chk("post_idle", {busy, miss_ack, tag_wr_en}, 0);
  endtask

  initial begin
    rst = 1'b1;
    step();
    step();
    chk("reset_outs_zero", all_outs(), 0);
    rst = 1'b0;
    step();

    // Basic refill, with the literal expectations cross-checked up front.
    chk("t1_expected_tag", 16'h1A36 >> 10, 16'h0006);
    do_miss(16'h1A36, 4'b0100, 0, 0, 1'b0, -1, 1'b0, 16'h0);
    // Request stall of 5 cycles.
    do_miss(16'($urandom), 4'b0001, 5, 0, 1'b0, -1, 1'b0, 16'h0);
    // Gapped beats plus a stray beat in the handshake cycle.
    do_miss(16'($urandom), 4'b1000, 0, 3, 1'b1, -1, 1'b0, 16'h0);
    // Way normalization.
    do_miss(16'($urandom), 4'b0000, 0, 0, 1'b0, -1, 1'b0, 16'h0);
    do_miss(16'($urandom), 4'b1010, 1, 0, 1'b0, -1, 1'b0, 16'h0);
    // Reset mid-fill, then a normal miss.
    do_miss(16'($urandom), 4'b0010, 0, 0, 1'b0, 2, 1'b0, 16'h0);
    do_miss(16'h5A5F, 4'b0001, 0, 0, 1'b0, -1, 1'b0, 16'h0);
    // Busy lockout: second address presented while the first is in flight.
    do_miss(16'hC3A4, 4'b0100, 0, 0, 1'b0, -1, 1'b1, 16'h3C58);
    do_miss(16'h3C58, 4'b0010, 0, 0, 1'b0, -1, 1'b0, 16'h0);

    for (int n = 0; n < 25; n++) begin
      do_miss(16'($urandom), 4'($urandom), int'($urandom_range(0, 3)), -1,
              1'($urandom), -1, 1'b0, 16'h0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cache_refill_ctrl.md
CACHE_REFILL_CTRL -- requirements
Module: cache_refill_ctrl

Interface
REQ-001 Parameter DATA_W, default 32: width of one memory data beat and of one cache word.
REQ-002 Parameter BEATS, default 4: words per line, a power of two in 2..8; OFS_W = log2(BEATS), TAG_W = 16-8-OFS_W.
REQ-003 Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 miss_req  in  1  miss pending; accepted only when busy=0.
REQ-007 miss_addr  in  16  word address of the miss: {tag, index[7:0], offset}.
REQ-008 busy  out  1  high from the cycle after acceptance through the DONE cycle.
REQ-009 miss_ack  out  1  one-cycle pulse: line installed.
REQ-010 repl_enable  out  1  one-cycle victim-request pulse to the replacement unit.
REQ-011 repl_set_addr  out  8  set index presented with repl_enable.
REQ-012 repl_way_sel  in  4  victim way, one-hot, valid the cycle after repl_enable.
REQ-013 mem_rd_valid / mem_rd_ready  out / in  1 / 1  line-read request handshake.
REQ-014 mem_rd_addr  out  16  line-aligned address (offset bits zero).
REQ-015 mem_data_valid / mem_data  in  1 / DATA_W  returned beats, offset 0 first; no back-pressure.
REQ-016 wr_en, wr_way[3:0], wr_set[7:0], wr_word[OFS_W-1:0], wr_data[DATA_W-1:0]  out  data-array write port.
REQ-017 tag_wr_en, tag_wr[TAG_W-1:0]  out  tag write for wr_way/wr_set; also sets that way's valid bit.

Function
REQ-018 FSM states: IDLE, VICTIM, WAIT_WAY, REQ, FILL, DONE.
REQ-019 IDLE: if miss_req=1, capture miss_addr into an internal register and go to VICTIM; otherwise stay in IDLE.
REQ-020 VICTIM: repl_enable=1 for exactly this one cycle, repl_set_addr=captured index; go to WAIT_WAY.
REQ-021 WAIT_WAY: register repl_way_sel; go to REQ. Multi-hot input: keep lowest set bit. All-zero input: use way 0.
REQ-022 REQ: mem_rd_valid=1, mem_rd_addr held stable until the cycle with mem_rd_ready=1; then go to FILL with beat counter=0.
REQ-023 FILL: each cycle with mem_data_valid=1 drives wr_en=1 combinationally, with wr_data=mem_data, wr_word=counter, wr_way=registered way, wr_set=index; counter then increments.
REQ-024 On the beat with counter=BEATS-1, go to DONE; no wrap-around write occurs.
REQ-025 DONE: tag_wr_en=1 and miss_ack=1 for one cycle, tag_wr=captured tag; go to IDLE.
REQ-026 Minimum latency: request accepted at cycle t, with ready immediate and back-to-back beats, gives miss_ack at t+4+BEATS.
REQ-027 mem_data_valid outside FILL, including the handshake cycle itself, is ignored.
REQ-028 miss_req while busy=1 is ignored; the requester holds it until miss_ack.
REQ-029 When not driven by the state rules above, every output is 0.

Reset
REQ-030 rst=1 at a clock edge forces IDLE, counter 0 and the captured address/way registers to 0.
REQ-031 All outputs are 0 in the cycle after reset.
REQ-032 Reset during FILL aborts the refill: no further wr_en, no tag_wr_en, no miss_ack.
REQ-033 rst has priority over every simultaneous input.

Structure
REQ-034 Shared cache package holds NUM_SETS=256, NUM_WAYS=4, INDEX_W=8 and the FSM state enumeration.
REQ-035 One combinational sub-module, way_onehot_normalize, implements REQ-021; the FSM and counter stay inline.

Verification
REQ-036 Test 1 (basic refill)
- Stimulus: miss_addr=0x1A36, repl_way_sel=0100, ready immediate, beats D0..D3 back-to-back.
- Required response: repl_set_addr=0x8D; mem_rd_addr=0x1A34; writes to set 0x8D, way 0100, words 0..3; tag_wr=0x06; miss_ack at t+8.
REQ-037 Test 2 (request stall)
- Stimulus: mem_rd_ready held low for 5 cycles.
- Required response: mem_rd_valid stays 1 and mem_rd_addr stays constant; miss_ack is delayed by 5 cycles.
REQ-038 Test 3 (gapped beats)
- Stimulus: 3 idle cycles between beats, plus a stray mem_data_valid in the REQ handshake cycle.
- Required response: exactly 4 writes, wr_word 0..3, and the stray beat is ignored.
REQ-039 Test 4 (way normalization)
- Stimulus: repl_way_sel=0000, then 1010.
- Required response: wr_way=0001, then 0010.
REQ-040 Test 5 (reset mid-fill)
- Stimulus: rst asserted after the 2nd beat.
- Required response: no tag_wr_en or miss_ack; all outputs 0; the next miss completes normally.
REQ-041 Test 6 (busy lockout)
- Stimulus: a second miss_addr presented while busy=1.
- Required response: the first miss completes with its own tag; the second is accepted only in IDLE.
